// File: rtl/ex_muldiv_unit.sv
// Iterative RISC-V M-extension execute unit: fixed-latency multiplier and a
// radix-2 restoring divider behind a single valid/ready request/result handshake.
module ex_muldiv_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [XLEN-1:0]  i_a,
    input  logic [XLEN-1:0]  i_b,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_result,
    output logic [TAG_W-1:0] o_tag
);

    localparam int unsigned CntW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             is_rem_q, is_rem_d;
    logic [XLEN-1:0]  pres_q, pres_d;
    logic [TAG_W-1:0] ptag_q, ptag_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [TAG_W-1:0] otag_q, otag_d;

    // Multiplier: operands sign/zero-extended to 2*XLEN so a plain product is exact.
    logic              a_sext, b_sext;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0]   mul_res;

    always_comb begin
        a_sext  = (i_op[1:0] == 2'd1 || i_op[1:0] == 2'd2) && i_a[XLEN-1];
        b_sext  = (i_op[1:0] == 2'd1) && i_b[XLEN-1];
        mul_a   = {{XLEN{a_sext}}, i_a};
        mul_b   = {{XLEN{b_sext}}, i_b};
        prod    = mul_a * mul_b;
        mul_res = (i_op[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // Divider setup decoded at accept.
    logic            div_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    always_comb begin
        div_sgn  = ~i_op[0];
        a_neg    = div_sgn & i_a[XLEN-1];
        b_neg    = div_sgn & i_b[XLEN-1];
        a_mag    = a_neg ? (~i_a + 1'b1) : i_a;
        b_mag    = b_neg ? (~i_b + 1'b1) : i_b;
        div_zero = (i_b == '0);
        div_ovf  = div_sgn && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1);
        if (div_zero) begin
            special_res = i_op[1] ? i_a : '1;
        end else begin
            special_res = i_op[1] ? '0 : i_a;
        end
    end

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] quo_nx, rem_nx, quo_fin, rem_fin;

    always_comb begin
        rem_sh  = {rem_q, quo_q[XLEN-1]};
        diff    = rem_sh - {1'b0, dvs_q};
        quo_nx  = {quo_q[XLEN-2:0], ~diff[XLEN]};
        rem_nx  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        quo_fin = qneg_q ? (~quo_nx + 1'b1) : quo_nx;
        rem_fin = rneg_q ? (~rem_nx + 1'b1) : rem_nx;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        is_rem_d = is_rem_q;
        pres_d   = pres_q;
        ptag_d   = ptag_q;
        res_d    = res_q;
        otag_d   = otag_q;

        if (i_flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        ptag_d = i_tag;
                        cnt_d  = '0;
                        if (!i_op[2]) begin
                            if (MUL_STAGES == 1) begin
                                state_d = StDone;
                                res_d   = mul_res;
                                otag_d  = i_tag;
                            end else begin
                                state_d = StMul;
                                pres_d  = mul_res;
                            end
                        end else if (div_zero || div_ovf) begin
                            state_d = StDone;
                            res_d   = special_res;
                            otag_d  = i_tag;
                        end else begin
                            state_d  = StDiv;
                            quo_d    = a_mag;
                            rem_d    = '0;
                            dvs_d    = b_mag;
                            qneg_d   = a_neg ^ b_neg;
                            rneg_d   = a_neg;
                            is_rem_d = i_op[1];
                        end
                    end
                end
                StMul: begin
                    if (cnt_q == CntW'(MUL_STAGES - 2)) begin
                        state_d = StDone;
                        res_d   = pres_q;
                        otag_d  = ptag_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StDiv: begin
                    quo_d = quo_nx;
                    rem_d = rem_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(XLEN - 1)) begin
                        state_d = StDone;
                        res_d   = is_rem_q ? rem_fin : quo_fin;
                        otag_d  = ptag_q;
                    end
                end
                StDone: begin
                    if (i_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            is_rem_q <= 1'b0;
            pres_q   <= '0;
            ptag_q   <= '0;
            res_q    <= '0;
            otag_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            is_rem_q <= is_rem_d;
            pres_q   <= pres_d;
            ptag_q   <= ptag_d;
            res_q    <= res_d;
            otag_q   <= otag_d;
        end
    end

    assign o_ready  = (state_q == StIdle);
    assign o_valid  = (state_q == StDone);
    assign o_result = res_q;
    assign o_tag    = otag_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit (XLEN=32, MUL_STAGES=2): expected result,
// tag and latency are queued at issue and compared when the result appears.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [4:0]  i_tag;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic [4:0]  o_tag;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    ex_muldiv_unit #(
        .XLEN      (32),
        .MUL_STAGES(2),
        .TAG_W     (5)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_tag   (i_tag),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_result(o_result),
        .o_tag   (o_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model straight from the RISC-V M definitions.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op < 3'd4) return 2;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Called at posedge+1; the next posedge is the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp_res, input int lat);
        exp_t e;
        check_eq("issue_ready", o_ready, 1);
        i_valid = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        i_tag   = tag;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_op    = 3'($urandom);
        i_a     = $urandom;
        i_b     = $urandom;
        i_tag   = 5'($urandom);
        e.res   = exp_res;
        e.tag   = tag;
        e.lat   = lat;
        sb_q.push_back(e);
    endtask

    task automatic issue_m(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag);
        issue(op, a, b, tag, model(op, a, b), exp_lat(op, a, b));
    endtask

    task automatic collect(input string name, input int hold);
        exp_t e;
        int   n;
        e = sb_q.pop_front();
        n = 1;
        while (!o_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({name, "_lat"}, n, e.lat);
        check_eq({name, "_res"}, o_result, e.res);
        check_eq({name, "_tag"}, o_tag, e.tag);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq({name, "_hold"}, {o_valid, o_ready, o_tag, o_result},
                     {1'b1, 1'b0, e.tag, e.res});
        end
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        check_eq({name, "_idle"}, {o_valid, o_ready}, 2'b01);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (o_valid) seen++;
        end
        check_eq(name, seen, 0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        rst     = 1'b1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_op    = '0;
        i_a     = '0;
        i_b     = '0;
        i_tag   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_out", {o_valid, o_ready, o_tag, o_result}, {1'b0, 1'b1, 5'd0, 32'd0});
        rst = 1'b0;

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 2);
        collect("mul", 0);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 2);
        collect("mulhu", 0);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33);
        collect("div", 0);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);
        collect("rem", 0);
        issue(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33);
        collect("divu", 0);
        issue(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 33);
        collect("remu", 0);
        issue(3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);
        collect("divu_z", 0);
        issue(3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 1);
        collect("rem_z", 0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
        collect("div_ovf", 0);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1);
        collect("rem_ovf", 0);

        // Result held across consumer back-pressure.
        issue_m(3'd1, 32'h8000_0001, 32'h7FFF_FFFF, 5'd13);
        collect("mulh_hold", 3);
        issue_m(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd14);
        collect("mulhsu", 0);

        for (int k = 0; k < 16; k++) begin
            op = 3'(k % 8);
            a  = $urandom;
            b  = (k % 5 == 4) ? 32'd0 : ($urandom >> (k % 3) * 8);
            issue_m(op, a, b, 5'(k + 16));
            collect("rand", k % 3);
        end

        // Flush on the 10th DIV cycle.
        issue_m(3'd4, 32'd1000, 32'd3, 5'd1);
        void'(sb_q.pop_back());
        repeat (9) @(posedge clk);
        #1;
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        check_eq("flush_state", {o_valid, o_ready}, 2'b01);
        expect_quiet("flush_quiet", 40);
        issue(3'd0, 32'd3, 32'd4, 5'd2, 32'd12, 2);
        collect("mul_after_flush", 0);

        // Reset during DIV.
        issue_m(3'd5, 32'd77, 32'd5, 5'd20);
        void'(sb_q.pop_back());
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_div", {o_valid, o_ready, o_tag, o_result}, {1'b0, 1'b1, 5'd0, 32'd0});
        expect_quiet("rst_div_quiet", 40);

        // Reset while a result waits in DONE.
        issue_m(3'd0, 32'd9, 32'd9, 5'd21);
        void'(sb_q.pop_back());
        @(posedge clk);
        #1;
        check_eq("done_before_rst", o_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_done", {o_valid, o_ready, o_tag, o_result}, {1'b0, 1'b1, 5'd0, 32'd0});
        expect_quiet("rst_done_quiet", 10);

        issue_m(3'd7, 32'hDEAD_BEEF, 32'd1234, 5'd22);
        collect("remu_after_rst", 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
